// File: rtl/branch_pkg.sv
// Shared opcode, tipo and FSM definitions for branch detection.
// Imported by opcode_decoder and branch_detection.
package branch_pkg;

  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b000101;
  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  localparam logic [1:0] TIPO_NONE = 2'b00;
  localparam logic [1:0] TIPO_BEQ  = 2'b01;
  localparam logic [1:0] TIPO_BNE  = 2'b10;
  localparam logic [1:0] TIPO_JMP  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_SHADOW
  } br_state_e;

endpackage

// File: rtl/branch_detection_opcode_decoder.sv
// Combinational opcode classifier.
// Ports: instruccion in; is_branch, is_jump, tipo_raw out.
module opcode_decoder
  import branch_pkg::*;
(
  input  logic [5:0] instruccion,
  output logic       is_branch,
  output logic       is_jump,
  output logic [1:0] tipo_raw
);

  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    tipo_raw  = TIPO_NONE;
    unique case (1'b1)
      (instruccion == OPC_BEQ): begin
        is_branch = 1'b1;
        tipo_raw  = TIPO_BEQ;
      end
      (instruccion == OPC_BNE): begin
        is_branch = 1'b1;
        tipo_raw  = TIPO_BNE;
      end
      (instruccion == OPC_J),
      (instruccion == OPC_JAL): begin
        is_jump  = 1'b1;
        tipo_raw = TIPO_JMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_detection.sv
// Branch/jump detector with squash shadow and saturating event counters.
// Ports: clk, rst, instruccion in; es_branch, es_jump, flush, tipo, counters out.
module branch_detection
  import branch_pkg::*;
#(
  parameter int BR_SHADOW = 2,
  parameter int J_SHADOW  = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instruccion,
  output logic             es_branch,
  output logic             es_jump,
  output logic             flush,
  output logic [1:0]       tipo,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jump
);

  localparam logic [2:0] BR_LD = 3'(BR_SHADOW - 1);
  localparam logic [2:0] J_LD  = 3'(J_SHADOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       raw_branch;
  logic       raw_jump;
  logic [1:0] raw_tipo;

  br_state_e        state_q, state_d;
  logic [2:0]       sh_q, sh_d;
  logic             flush_q, flush_d;
  logic [1:0]       tipo_q, tipo_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_j_q, cnt_j_d;

  opcode_decoder u_dec (
    .instruccion (instruccion),
    .is_branch   (raw_branch),
    .is_jump     (raw_jump),
    .tipo_raw    (raw_tipo)
  );

  // Decode slot holds a wrong-path op while flushing.
  assign es_branch = raw_branch & ~flush_q;
  assign es_jump   = raw_jump & ~flush_q;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    flush_d  = flush_q;
    tipo_d   = tipo_q;
    cnt_br_d = cnt_br_q;
    cnt_j_d  = cnt_j_q;
    unique case (state_q)
      ST_IDLE: begin
        if (es_branch || es_jump) begin
          state_d = ST_SHADOW;
          flush_d = 1'b1;
          tipo_d  = raw_tipo;
          if (es_branch) begin
            sh_d = BR_LD;
            if (cnt_br_q != CNT_MAX)
              cnt_br_d = cnt_br_q + 1'b1;
          end else begin
            sh_d = J_LD;
            if (cnt_j_q != CNT_MAX)
              cnt_j_d = cnt_j_q + 1'b1;
          end
        end
      end
      ST_SHADOW: begin
        if (sh_q == 3'd0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
          tipo_d  = TIPO_NONE;
        end else begin
          sh_d = sh_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        flush_d = 1'b0;
        tipo_d  = TIPO_NONE;
        sh_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sh_q     <= 3'd0;
      flush_q  <= 1'b0;
      tipo_q   <= TIPO_NONE;
      cnt_br_q <= '0;
      cnt_j_q  <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      flush_q  <= flush_d;
      tipo_q   <= tipo_d;
      cnt_br_q <= cnt_br_d;
      cnt_j_q  <= cnt_j_d;
    end
  end

  assign flush      = flush_q;
  assign tipo       = tipo_q;
  assign cnt_branch = cnt_br_q;
  assign cnt_jump   = cnt_j_q;

endmodule

// File: tb/tb_branch_detection.sv
// Directed self-checking bench for branch_detection.
// Drives a default instance and a CNT_W=2 instance.
module tb_branch_detection;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  instr;
  logic        es_branch, es_jump, flush;
  logic [1:0]  tipo;
  logic [15:0] cnt_b, cnt_j;

  logic        rst2;
  logic [5:0]  instr2;
  logic        es_branch2, es_jump2, flush2;
  logic [1:0]  tipo2;
  logic [1:0]  cnt_b2, cnt_j2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_detection dut (
    .clk         (clk),
    .rst         (rst),
    .instruccion (instr),
    .es_branch   (es_branch),
    .es_jump     (es_jump),
    .flush       (flush),
    .tipo        (tipo),
    .cnt_branch  (cnt_b),
    .cnt_jump    (cnt_j)
  );

  branch_detection #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst2),
    .instruccion (instr2),
    .es_branch   (es_branch2),
    .es_jump     (es_jump2),
    .flush       (flush2),
    .tipo        (tipo2),
    .cnt_branch  (cnt_b2),
    .cnt_jump    (cnt_j2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [5:0] op,
                      input logic ef, input logic [1:0] et);
    instr = op;
    tick();
    chk({tag, " flush"}, 32'(flush), 32'(ef));
    chk({tag, " tipo"}, 32'(tipo), 32'(et));
  endtask

  task automatic sat_accept(input string tag, input logic [1:0] exp);
    instr2 = 6'b000100;
    tick();
    chk({tag, " flush"}, 32'(flush2), 32'd1);
    chk({tag, " cnt"}, 32'(cnt_b2), 32'(exp));
    instr2 = 6'b000000;
    tick();
    tick();
    chk({tag, " idle"}, 32'(flush2), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    instr = 6'b000000;
    rst2 = 1'b1;
    instr2 = 6'b000000;
    tick();
    tick();
    rst = 1'b0;
    rst2 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step("idle0", 6'b000000, 1'b0, 2'b00);
    end
    chk("idle0 cnt_b", 32'(cnt_b), 32'd0);
    chk("idle0 cnt_j", 32'(cnt_j), 32'd0);

    rst = 1'b1;
    instr = 6'b000100;
    #1;
    chk("rst es_branch", 32'(es_branch), 32'd1);
    tick();
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst cnt_b", 32'(cnt_b), 32'd0);
    chk("rst es_branch2", 32'(es_branch), 32'd1);
    tick();
    chk("rst flush2", 32'(flush), 32'd0);

    rst = 1'b0;
    step("beq acc", 6'b000100, 1'b1, 2'b01);
    chk("beq cnt_b", 32'(cnt_b), 32'd1);
    chk("beq mask", 32'(es_branch), 32'd0);
    step("beq sh2", 6'b000000, 1'b1, 2'b01);
    step("beq end", 6'b000000, 1'b0, 2'b00);
    step("beq idle", 6'b000000, 1'b0, 2'b00);
    chk("beq cnt_b2", 32'(cnt_b), 32'd1);

    step("bne c1", 6'b000101, 1'b1, 2'b10);
    chk("bne cnt1", 32'(cnt_b), 32'd2);
    step("bne c2", 6'b000101, 1'b1, 2'b10);
    step("bne c3", 6'b000101, 1'b0, 2'b00);
    step("bne c4", 6'b000101, 1'b1, 2'b10);
    chk("bne cnt2", 32'(cnt_b), 32'd3);
    step("j c1", 6'b000010, 1'b1, 2'b10);
    step("j c2", 6'b000010, 1'b0, 2'b00);
    chk("j es_jump", 32'(es_jump), 32'd1);
    step("j c3", 6'b000010, 1'b1, 2'b11);
    chk("j cnt_j", 32'(cnt_j), 32'd1);
    chk("j mask", 32'(es_jump), 32'd0);
    step("j c4", 6'b000010, 1'b0, 2'b00);
    step("jal", 6'b000011, 1'b1, 2'b11);
    chk("jal cnt_j", 32'(cnt_j), 32'd2);
    step("jal end", 6'b000000, 1'b0, 2'b00);

    instr = 6'b111111;
    #1;
    chk("bad es_branch", 32'(es_branch), 32'd0);
    chk("bad es_jump", 32'(es_jump), 32'd0);
    step("bad1", 6'b111111, 1'b0, 2'b00);
    step("bad2", 6'b000001, 1'b0, 2'b00);
    chk("bad cnt_b", 32'(cnt_b), 32'd3);
    chk("bad cnt_j", 32'(cnt_j), 32'd2);

    step("abort acc", 6'b000100, 1'b1, 2'b01);
    rst = 1'b1;
    instr = 6'b000000;
    tick();
    chk("abort flush", 32'(flush), 32'd0);
    chk("abort tipo", 32'(tipo), 32'd0);
    chk("abort cnt_b", 32'(cnt_b), 32'd0);
    chk("abort cnt_j", 32'(cnt_j), 32'd0);
    rst = 1'b0;
    step("post abort", 6'b000000, 1'b0, 2'b00);

    sat_accept("sat1", 2'd1);
    sat_accept("sat2", 2'd2);
    sat_accept("sat3", 2'd3);
    sat_accept("sat4", 2'd3);
    sat_accept("sat5", 2'd3);
    chk("sat cnt_j", 32'(cnt_j2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
